cdb_arbiter: RTL and testbench

- Parametrised successor of the two-unit ALU/LS result arbiter.
- Arbitrates NUM_REQ execution units for a single common-data-bus (CDB) writeback slot each cycle.
- Stalls the losers and registers the winner's result onto the CDB.
- Sits between the functional units (ALU, LS, MUL, ...) and the ROB/reservation-station wakeup logic.

---
 rtl/cdb_arbiter.sv | 155 +++++++++++++++
 tb/tb_cdb_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// -----------------------------------------------------------------------------
// cdb_arbiter
//
// Purpose:
//   Arbitrates NUM_REQ execution units (channel 0 = ALU, channel 1 = LS, ...)
//   for the single common-data-bus writeback slot. The winner is chosen
//   combinationally in the request cycle; its payload and index are registered
//   onto the CDB at the end of that cycle. Losers see stall and must hold their
//   request and payload stable; nothing is buffered here.
//
// Optional feature:
//   CDB_STARVE_GUARD_EN - when defined, every channel gets a saturating 4-bit
//   wait counter. A requesting channel whose counter equals STARVE_LIMIT is
//   urgent and beats every non-urgent channel. When undefined, the arbiter is
//   pure fixed priority and STARVE_LIMIT has no effect.
//
// Ports:
//   clk       in   system clock, rising-edge active
//   rst       in   synchronous, active-high reset
//   req       in   [NUM_REQ]         per-unit "result ready" request
//   req_data  in   [NUM_REQ*DATA_W]  packed payloads, channel i at [i*DATA_W +: DATA_W]
//   cdb_hold  in   downstream cannot accept a CDB write this cycle
//   grant     out  [NUM_REQ]  one-hot (or zero) combinational grant
//   stall     out  [NUM_REQ]  combinational, req & ~grant
//   cdb_valid out  registered CDB valid
//   cdb_data  out  [DATA_W]   registered winning payload
//   cdb_src   out  [SRC_W]    registered winning channel index
// -----------------------------------------------------------------------------
module cdb_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int DATA_W       = 32,
    parameter int SRC_W        = 2,
    parameter int STARVE_LIMIT = 7
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic                      cdb_hold,
    output logic [NUM_REQ-1:0]        grant,
    output logic [NUM_REQ-1:0]        stall,
    output logic                      cdb_valid,
    output logic [DATA_W-1:0]         cdb_data,
    output logic [SRC_W-1:0]          cdb_src
);

    // Elaboration-time parameter sanity checks.
    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
        $error("cdb_arbiter: NUM_REQ must be in 2..8");
    end
    if (SRC_W < $clog2(NUM_REQ)) begin : g_bad_src_w
        $error("cdb_arbiter: SRC_W too narrow for NUM_REQ");
    end
    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
        $error("cdb_arbiter: STARVE_LIMIT must be in 1..15");
    end

    // Channels eligible for the fixed-priority scan this cycle.
    logic [NUM_REQ-1:0] w_cand;
    logic [NUM_REQ-1:0] w_grant;
    logic [SRC_W-1:0]   w_win_idx;
    logic [DATA_W-1:0]  w_win_data;

    logic               r_cdb_valid;
    logic [DATA_W-1:0]  r_cdb_data;
    logic [SRC_W-1:0]   r_cdb_src;

`ifdef CDB_STARVE_GUARD_EN
    logic [3:0]         r_wait [NUM_REQ];
    logic [NUM_REQ-1:0] w_urgent;

    // Urgency is qualified with req so a channel that drops its request while
    // its counter still sits at the limit can never be granted.
    always_comb begin : p_urgent
        w_urgent = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_urgent[i] = req[i] && (r_wait[i] == 4'(STARVE_LIMIT));
        end
    end

    // Any urgent channel pre-empts the normal set; lowest index still decides.
    assign w_cand = (|w_urgent) ? w_urgent : req;

    // Wait counters freeze entirely while the CDB is held, otherwise count
    // lost arbitration rounds and clear on grant or when the request drops.
    always_ff @(posedge clk) begin : p_wait
        if (rst) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                r_wait[i] <= '0;
            end
        end else if (!cdb_hold) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req[i] && !w_grant[i]) begin
                    if (r_wait[i] != 4'hF) begin
                        r_wait[i] <= r_wait[i] + 4'd1;
                    end
                end else begin
                    r_wait[i] <= '0;
                end
            end
        end
    end
`else
    assign w_cand = req;
`endif

    // Fixed-priority pick: scan from the top down so the lowest asserted
    // index is the last writer and therefore the winner.
    always_comb begin : p_pick
        // NOTE: every output of a combinational block gets a default up front;
        // a path that skips an assignment would otherwise infer a latch.
        w_grant    = '0;
        w_win_idx  = '0;
        w_win_data = '0;
        if (!cdb_hold) begin
            for (int i = NUM_REQ - 1; i >= 0; i--) begin
                if (w_cand[i]) begin
                    w_grant    = '0;
                    w_grant[i] = 1'b1;
                    w_win_idx  = SRC_W'(i);
                    w_win_data = req_data[i*DATA_W +: DATA_W];
                end
            end
        end
    end

    // CDB register: hold freezes everything so a pending write survives until
    // accepted; an idle cycle only drops valid and keeps the last payload.
    always_ff @(posedge clk) begin : p_cdb
        // NOTE: the payload and index are reset along with valid because the
        // downstream consumers expect a defined CDB image out of reset, not X.
        if (rst) begin
            // NOTE: state registers use non-blocking assignments so every flop
            // samples pre-edge values regardless of statement order.
            r_cdb_valid <= 1'b0;
            r_cdb_data  <= '0;
            r_cdb_src   <= '0;
        end else if (!cdb_hold) begin
            if (|w_grant) begin
                r_cdb_valid <= 1'b1;
                r_cdb_data  <= w_win_data;
                r_cdb_src   <= w_win_idx;
            end else begin
                r_cdb_valid <= 1'b0;
            end
        end
    end

    assign grant     = w_grant;
    assign stall     = req & ~w_grant;
    assign cdb_valid = r_cdb_valid;
    assign cdb_data  = r_cdb_data;
    assign cdb_src   = r_cdb_src;

endmodule

// File: tb/tb_cdb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cdb_arbiter
//
// Self-checking bench for cdb_arbiter (NUM_REQ=4, DATA_W=32, SRC_W=2,
// STARVE_LIMIT=3). A behavioural model picks the winner from the arbitration
// rules and tracks the expected CDB image; a compare process checks the DUT
// against it every cycle. Directed scenarios pin the model with literal values,
// then randomized traffic (stalled units keep their request stable most of the
// time) runs against the model. Build with +define+CDB_STARVE_GUARD_EN to cover
// the starvation guard.
// -----------------------------------------------------------------------------
module tb_cdb_arbiter;

    localparam int LIMIT = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   req;
    logic [127:0] req_data;
    logic         cdb_hold;
    logic [3:0]   grant;
    logic [3:0]   stall;
    logic         cdb_valid;
    logic [31:0]  cdb_data;
    logic [1:0]   cdb_src;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;

    // Model state: expected CDB image and per-channel lost-round counts.
    logic        m_valid;
    logic [31:0] m_data;
    logic [1:0]  m_src;
    int          m_wait [4];

    cdb_arbiter #(
        .NUM_REQ     (4),
        .DATA_W      (32),
        .SRC_W       (2),
        .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_data (req_data),
        .cdb_hold (cdb_hold),
        .grant    (grant),
        .stall    (stall),
        .cdb_valid(cdb_valid),
        .cdb_data (cdb_data),
        .cdb_src  (cdb_src)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Winner index under the arbitration rules, or -1 for no grant.
    function automatic int pick_winner(input logic [3:0] r, input logic h);
        if (h) return -1;
`ifdef CDB_STARVE_GUARD_EN
        for (int i = 0; i < 4; i++) begin
            if (r[i] && m_wait[i] == LIMIT) return i;
        end
`endif
        for (int i = 0; i < 4; i++) begin
            if (r[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [3:0] exp_grant();
        int w;
        w = pick_winner(req, cdb_hold);
        return (w < 0) ? 4'b0000 : 4'(1 << w);
    endfunction

    // Model update at each rising edge (inputs change only #1 after the edge).
    always @(posedge clk) begin : model
        int w;
        w = pick_winner(req, cdb_hold);
        if (rst) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_src   <= '0;
            for (int i = 0; i < 4; i++) m_wait[i] <= 0;
        end else if (!cdb_hold) begin
            if (w >= 0) begin
                m_valid <= 1'b1;
                m_data  <= req_data[w*32 +: 32];
                m_src   <= 2'(w);
            end else begin
                m_valid <= 1'b0;
            end
            for (int i = 0; i < 4; i++) begin
                if (req[i] && i != w) m_wait[i] <= (m_wait[i] < 15) ? m_wait[i] + 1 : 15;
                else                  m_wait[i] <= 0;
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin : compare
        logic [3:0] eg;
        if (cmp_en) begin
            eg = exp_grant();
            check("grant",     grant,     eg);
            check("stall",     stall,     req & ~eg);
            check("cdb_valid", cdb_valid, m_valid);
            check("cdb_data",  cdb_data,  m_data);
            check("cdb_src",   cdb_src,   m_src);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin : stim
        logic [3:0] prev_stall;
        logic [3:0] exp_g;

        // Reset with every unit requesting.
        rst      = 1'b1;
        cdb_hold = 1'b0;
        req      = 4'b1111;
        req_data = {32'hA000_0003, 32'hA000_0002, 32'hA000_0001, 32'hA000_0000};
        tick();
        cmp_en = 1'b1;
        check("rst_valid", cdb_valid, 1'b0);
        check("rst_data",  cdb_data,  32'h0);
        check("rst_src",   cdb_src,   2'd0);
        check("rst_grant", grant,     4'b0001);
        tick();
        rst = 1'b0;
        tick();
        check("post_rst_valid", cdb_valid, 1'b1);
        check("post_rst_src",   cdb_src,   2'd0);
        check("post_rst_data",  cdb_data,  32'hA000_0000);

        // Single request on channel 2.
        req = 4'b0100;
        req_data[2*32 +: 32] = 32'hDEAD_BEEF;
        #1;
        check("single_grant", grant, 4'b0100);
        check("single_stall", stall, 4'b0000);
        tick();
        check("single_valid", cdb_valid, 1'b1);
        check("single_data",  cdb_data,  32'hDEAD_BEEF);
        check("single_src",   cdb_src,   2'd2);

        // ALU/LS contention, then ALU drops out.
        req = 4'b0011;
        req_data[0 +: 32]  = 32'h1;
        req_data[32 +: 32] = 32'h2;
        #1;
        check("cont_grant", grant, 4'b0001);
        check("cont_stall", stall, 4'b0010);
        tick();
        check("cont_data0", cdb_data, 32'h1);
        check("cont_src0",  cdb_src,  2'd0);
        req = 4'b0010;
        #1;
        check("cont_grant_ls", grant, 4'b0010);
        tick();
        check("cont_data1",  cdb_data,  32'h2);
        check("cont_src1",   cdb_src,   2'd1);
        check("cont_valid1", cdb_valid, 1'b1);

        // Hold for three cycles with channel 3 waiting.
        req = 4'b1000;
        req_data[3*32 +: 32] = 32'hC0DE_0003;
        cdb_hold = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            check("hold_grant", grant, 4'b0000);
            check("hold_stall", stall, 4'b1000);
            tick();
            check("hold_valid", cdb_valid, 1'b1);
            check("hold_data",  cdb_data,  32'h2);
            check("hold_src",   cdb_src,   2'd1);
        end
        cdb_hold = 1'b0;
        #1;
        check("release_grant", grant, 4'b1000);
        tick();
        check("release_valid", cdb_valid, 1'b1);
        check("release_src",   cdb_src,   2'd3);
        check("release_data",  cdb_data,  32'hC0DE_0003);

        // Idle cycle: valid drops, payload is kept.
        req = 4'b0000;
        tick();
        check("idle_valid", cdb_valid, 1'b0);
        check("idle_data",  cdb_data,  32'hC0DE_0003);
        check("idle_src",   cdb_src,   2'd3);

        // ALU requests continuously alongside channel 3.
        req = 4'b1001;
        for (int c = 1; c <= 6; c++) begin
            #1;
`ifdef CDB_STARVE_GUARD_EN
            exp_g = (c == 4) ? 4'b1000 : 4'b0001;
`else
            exp_g = 4'b0001;
`endif
            check("starve_grant", grant, exp_g);
            tick();
        end

        // Randomized traffic; stalled units usually keep request and payload.
        for (int c = 0; c < 2000; c++) begin
            prev_stall = req & ~exp_grant();
            tick();
            rst      = ($urandom_range(0, 99) == 0);
            cdb_hold = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < 4; i++) begin
                if (!(prev_stall[i] && $urandom_range(0, 9) != 0)) begin
                    req[i] = 1'($urandom_range(0, 1));
                    req_data[i*32 +: 32] = $urandom;
                end
            end
        end

        tick();
        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
